// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap_pkg
//  Description : Shared definitions for the SAP-style adder/subtractor block.
//                Holds the controller state encoding and the all-ones value
//                presented on the W bus when the result is not enabled.
//  Contents    : state_t   - IDLE / CALC / HOLD controller states
//                BUS_IDLE  - all-ones bus-idle pattern, sliced to width
//                            by the user (supports widths up to 64)
//  Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      HOLD = 2'b10
   } state_t;

   localparam int                       BUS_MAX_WIDTH = 64;
   localparam logic [BUS_MAX_WIDTH-1:0] BUS_IDLE      = {BUS_MAX_WIDTH{1'b1}};

endpackage : sap_pkg
`default_nettype wire

// File: rtl/b_register.sv
`default_nettype none
// ============================================================================
//  Module      : b_register
//  Description : Operand B holding register, loaded from the W bus.
//  Ports       : CLK      in   system clock, rising edge
//                CLR_bar  in   asynchronous active-low clear
//                Lb_bar   in   active-low load enable
//                data_in  in   W bus value [WIDTH]
//                b_out    out  stored operand [WIDTH]
//  Revision    : 1.0 - initial release
// ============================================================================
module b_register #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             CLR_bar,
   input  logic             Lb_bar,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] b_out
);

   // A load on the same edge as a calculation is fine: the datapath reads
   // b_out before this edge updates it, so the calculation sees the old B.
   always_ff @(posedge CLK or negedge CLR_bar) begin
      if (!CLR_bar) begin
         b_out <= '0;
      end else if (!Lb_bar) begin
         b_out <= data_in;
      end
   end

endmodule : b_register
`default_nettype wire

// File: rtl/adder_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : adder_subtractor
//  Description : Registered adder/subtractor for a SAP-style W bus. A start
//                pulse captures the operation, the next edge computes
//                acc_in +/- B into a result register, after which the result
//                is held (valid) until re-started or read out with Eu.
//  Ports       : CLK         in   system clock, rising edge
//                CLR_bar     in   asynchronous active-low reset
//                Lb_bar      in   active-low load of B from data_in
//                Su          in   0 = add, 1 = subtract (sampled on start)
//                start       in   one-cycle compute request
//                Eu          in   drive result onto the W bus
//                data_in     in   W bus value [WIDTH]
//                acc_in      in   accumulator value [WIDTH]
//                data_out    out  result when Eu=1, else all-ones [WIDTH]
//                busy        out  high in CALC
//                valid       out  high in HOLD
//                carry_flag  out  carry-out (add) / no-borrow (subtract)
//                zero_flag   out  result equals zero
//  Config      : ADDSUB_FLAGS_EN - when defined, carry_flag/zero_flag are
//                registered at the CALC edge; otherwise both are tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_subtractor
   import sap_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             CLR_bar,
   input  logic             Lb_bar,
   input  logic             Su,
   input  logic             start,
   input  logic             Eu,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] acc_in,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             valid,
   output logic             carry_flag,
   output logic             zero_flag
);

   // -------------------------------------------------------------------------
   // Operand B register
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] b_value;

   b_register #(
      .WIDTH (WIDTH)
   ) u_b_register (
      .CLK     (CLK),
      .CLR_bar (CLR_bar),
      .Lb_bar  (Lb_bar),
      .data_in (data_in),
      .b_out   (b_value)
   );

   // -------------------------------------------------------------------------
   // Datapath: subtract is acc + ~B + 1, so the carry-out of the widened sum
   // is the true carry for add and the no-borrow (acc >= B) for subtract.
   // -------------------------------------------------------------------------
   state_t           state;
   logic             op_sub;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] b_operand;
   logic [WIDTH:0]   sum_full;

   assign b_operand = op_sub ? ~b_value : b_value;
   assign sum_full  = {1'b0, acc_in} + {1'b0, b_operand} + {{WIDTH{1'b0}}, op_sub};

   // -------------------------------------------------------------------------
   // Controller and result register. busy/valid are registered alongside the
   // state so they change on exactly the same edge as the state does.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge CLR_bar) begin
      if (!CLR_bar) begin
         state  <= IDLE;
         op_sub <= 1'b0;
         result <= '0;
         busy   <= 1'b0;
         valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_sub <= Su;
                  state  <= CALC;
                  busy   <= 1'b1;
                  valid  <= 1'b0;
               end
            end
            CALC: begin
               // acc_in is taken here, not at the start edge
               result <= sum_full[WIDTH-1:0];
               state  <= HOLD;
               busy   <= 1'b0;
               valid  <= 1'b1;
            end
            HOLD: begin
               // a new start takes priority over reading the result out
               if (start) begin
                  op_sub <= Su;
                  state  <= CALC;
                  busy   <= 1'b1;
                  valid  <= 1'b0;
               end else if (Eu) begin
                  state  <= IDLE;
                  valid  <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               valid  <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Status flags
   // -------------------------------------------------------------------------
`ifdef ADDSUB_FLAGS_EN
   always_ff @(posedge CLK or negedge CLR_bar) begin
      if (!CLR_bar) begin
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
      end else if (state == CALC) begin
         carry_flag <= sum_full[WIDTH];
         zero_flag  <= (sum_full[WIDTH-1:0] == '0);
      end
   end
`else
   logic unused_carry;

   assign unused_carry = sum_full[WIDTH];
   assign carry_flag   = 1'b0;
   assign zero_flag    = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // W bus output: combinational in every state, all-ones when not enabled
   // -------------------------------------------------------------------------
   assign data_out = Eu ? result : BUS_IDLE[WIDTH-1:0];

endmodule : adder_subtractor
`default_nettype wire
